sequence_monitor: RTL and testbench
===================================

// Module: sequence_monitor
// PURPOSE
//   Downstream checker for the 3-bit repeating pattern 1,6,5,7,3,2,4 (period 7).
//   Samples din, acquires frame alignment on the value 1, and declares lock after
//   LOCK_PERIODS clean periods. Once locked, it flags every pattern break and keeps
//   saturating counters of good periods and errors for status/debug readout.
// PARAMETERS
//   LOCK_PERIODS  2  consecutive clean periods required to enter LOCKED (legal range 1..15)
//   CNT_W         8  width of period_cnt and err_cnt
// PORTS
//   clk         in   1      single clock, rising edge
//   rst         in   1      synchronous, active-high reset
//   din         in   3      sample from the pattern source
//   din_valid   in   1      din is sampled only when this is 1
//   cnt_clr     in   1      synchronous clear of period_cnt and err_cnt
//   locked      out  1      1 while the FSM is in LOCKED
//   expected    out  3      next value expected (pattern[idx]); 1 while in SEARCH
//   period_done out  1      1-cycle pulse: a full period completed while LOCKED
//   err         out  1      1-cycle pulse: mismatch while LOCKED
//   period_cnt  out  CNT_W  saturating count of completed LOCKED periods
//   err_cnt     out  CNT_W  saturating count of err pulses
// BEHAVIOUR
//   - Pattern table P[0..6] = 1,6,5,7,3,2,4. idx is 3 bits and wraps 6->0.
//   - Reset (rst=1 at an edge): state=SEARCH, idx=0, good=0. All outputs 0, except expected=1.
//   - Priority: rst > cnt_clr > count increment. cnt_clr with a simultaneous increment leaves the counter at 0.
//   - Outputs are registered. A sample taken at edge N is reflected in outputs after edge N.
//   - din_valid=0: state, idx, good and the counters all hold; period_done=0, err=0.
//   - SEARCH: valid & din==1 -> ACQUIRE, idx=1, good=0. Any other value stays in SEARCH.
//   - ACQUIRE: valid & din==P[idx] -> idx++.
//       On a match at idx=6, good++. If good reaches LOCK_PERIODS -> LOCKED, idx=0.
//       The locking period does not pulse period_done.
//     Mismatch -> no err. If din==1, stay in ACQUIRE with idx=1, good=0; otherwise go to SEARCH.
//   - LOCKED: valid & din==P[idx] -> idx++.
//       On a match at idx=6: period_done=1 and period_cnt++ (saturating at 2^CNT_W-1).
//     Mismatch: err=1, err_cnt++ (saturating), locked drops on the same edge.
//       If din==1 -> ACQUIRE, idx=1, good=0; otherwise -> SEARCH.
//   - Value 0 never occurs in the pattern, so it is always a mismatch.
//   - Startup tolerance: a repeated value before first lock (e.g. 1,6,6,...) never raises err.
//   - rst mid-operation discards alignment immediately; lock must be re-acquired from SEARCH.
// TESTING
//   1. rst, then 1,6,5,7,3,2,4 x2 with valid every cycle -> locked=1 after the 14th sample;
//      err=0, period_cnt=0.
//   2. Stream 1,6,6,5,7,3,2,4,1,6,5,7,3,2,4,1,6,5,7,3,2,4 -> err never 1, err_cnt=0;
//      locked=1 after sample 22.
//   3. Locked, then send 1,6,0 -> err pulses once after the 0; err_cnt=1, locked=0, expected=1.
//   4. Locked, with din_valid=0 gaps of 1..5 cycles inside a period -> no err;
//      period_done still pulses once per 7 valid samples.
//   5. CNT_W=2, locked, 5 periods -> period_cnt saturates at 3.
//      Then cnt_clr on the same cycle as the next period completion -> period_cnt=0.
//   6. rst asserted while locked mid-period -> next cycle locked=0, counters=0, expected=1;
//      relock requires LOCK_PERIODS clean periods.

Source files
------------

// File: rtl/sequence_monitor.sv
// Downstream checker for the period-7 pattern 1,6,5,7,3,2,4: acquires alignment on a 1,
// locks after LOCK_PERIODS clean periods, then flags breaks and counts periods/errors.
module sequence_monitor #(
    parameter int unsigned LOCK_PERIODS = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       din,
    input  logic             din_valid,
    input  logic             cnt_clr,
    output logic             locked,
    output logic [2:0]       expected,
    output logic             period_done,
    output logic             err,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_GOAL = 4'(LOCK_PERIODS);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    function automatic logic [2:0] pattern_at(input logic [2:0] i);
        logic [2:0] v;
        case (i)
            3'd0:    v = 3'd1;
            3'd1:    v = 3'd6;
            3'd2:    v = 3'd5;
            3'd3:    v = 3'd7;
            3'd4:    v = 3'd3;
            3'd5:    v = 3'd2;
            3'd6:    v = 3'd4;
            default: v = 3'd1;
        endcase
        return v;
    endfunction

    state_t     state_r;
    logic [2:0] idx_r;
    logic [3:0] good_r;

    logic       match_s;
    logic       last_s;
    logic       is_one_s;
    logic [2:0] idx_inc_s;
    logic [3:0] good_inc_s;
    logic       period_inc_s;
    logic       err_inc_s;

    // Compare the sample against the current pattern slot and derive the count events.
    always_comb begin
        match_s      = (din == pattern_at(idx_r));
        last_s       = (idx_r == 3'd6);
        is_one_s     = (din == 3'd1);
        idx_inc_s    = last_s ? 3'd0 : (idx_r + 3'd1);
        good_inc_s   = good_r + 4'd1;
        period_inc_s = din_valid && (state_r == ST_LOCKED) && match_s && last_s;
        err_inc_s    = din_valid && (state_r == ST_LOCKED) && !match_s;
    end

    // Alignment FSM; expected is loaded with the slot the next sample must hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_SEARCH;
            idx_r       <= 3'd0;
            good_r      <= 4'd0;
            locked      <= 1'b0;
            expected    <= 3'd1;
            period_done <= 1'b0;
            err         <= 1'b0;
        end else begin
            period_done <= period_inc_s;
            err         <= err_inc_s;
            if (din_valid) begin
                case (state_r)
                    ST_SEARCH: begin
                        if (is_one_s) begin
                            state_r  <= ST_ACQUIRE;
                            idx_r    <= 3'd1;
                            good_r   <= 4'd0;
                            expected <= pattern_at(3'd1);
                        end else begin
                            expected <= 3'd1;
                        end
                        locked <= 1'b0;
                    end
                    ST_ACQUIRE: begin
                        if (match_s) begin
                            idx_r    <= idx_inc_s;
                            expected <= pattern_at(idx_inc_s);
                            if (last_s && (good_inc_s == LOCK_GOAL)) begin
                                state_r <= ST_LOCKED;
                                good_r  <= 4'd0;
                                locked  <= 1'b1;
                            end else if (last_s) begin
                                good_r  <= good_inc_s;
                            end else begin
                                good_r  <= good_r;
                            end
                        end else if (is_one_s) begin
                            // A stray 1 restarts alignment rather than abandoning it.
                            idx_r    <= 3'd1;
                            good_r   <= 4'd0;
                            expected <= pattern_at(3'd1);
                        end else begin
                            state_r  <= ST_SEARCH;
                            idx_r    <= 3'd0;
                            good_r   <= 4'd0;
                            expected <= 3'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (match_s) begin
                            idx_r    <= idx_inc_s;
                            expected <= pattern_at(idx_inc_s);
                        end else if (is_one_s) begin
                            state_r  <= ST_ACQUIRE;
                            idx_r    <= 3'd1;
                            good_r   <= 4'd0;
                            locked   <= 1'b0;
                            expected <= pattern_at(3'd1);
                        end else begin
                            state_r  <= ST_SEARCH;
                            idx_r    <= 3'd0;
                            good_r   <= 4'd0;
                            locked   <= 1'b0;
                            expected <= 3'd1;
                        end
                    end
                    default: begin
                        state_r  <= ST_SEARCH;
                        idx_r    <= 3'd0;
                        good_r   <= 4'd0;
                        locked   <= 1'b0;
                        expected <= 3'd1;
                    end
                endcase
            end else begin
                state_r <= state_r;
                idx_r   <= idx_r;
                good_r  <= good_r;
            end
        end
    end

    // Saturating status counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt <= '0;
            err_cnt    <= '0;
        end else if (cnt_clr) begin
            period_cnt <= '0;
            err_cnt    <= '0;
        end else begin
            if (period_inc_s && (period_cnt != CNT_MAX)) begin
                period_cnt <= period_cnt + CNT_ONE;
            end else begin
                period_cnt <= period_cnt;
            end
            if (err_inc_s && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNT_ONE;
            end else begin
                err_cnt <= err_cnt;
            end
        end
    end

endmodule

// File: tb/tb_sequence_monitor.sv
// Bench for sequence_monitor: directed vector table, hand-written corner sequences,
// and random stimulus checked against a run-length reference model.
module tb_sequence_monitor;

    localparam int LOCK = 2;

    logic       clk = 1'b0;
    logic       rst, din_valid, cnt_clr;
    logic [2:0] din;

    logic       locked, period_done, err;
    logic [2:0] expected;
    logic [7:0] period_cnt, err_cnt;
    logic       s_locked, s_period_done, s_err;
    logic [2:0] s_expected;
    logic [1:0] s_period_cnt, s_err_cnt;

    always #5 clk = ~clk;

    sequence_monitor #(.LOCK_PERIODS(LOCK), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr),
        .locked(locked), .expected(expected), .period_done(period_done), .err(err),
        .period_cnt(period_cnt), .err_cnt(err_cnt)
    );

    sequence_monitor #(.LOCK_PERIODS(LOCK), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr),
        .locked(s_locked), .expected(s_expected), .period_done(s_period_done), .err(s_err),
        .period_cnt(s_period_cnt), .err_cnt(s_err_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] pat [7] = '{3'd1, 3'd6, 3'd5, 3'd7, 3'd3, 3'd2, 3'd4};

    // Reference model: m_run is the length of the current aligned run starting at a 1.
    int m_run = 0;
    int m_pcnt8 = 0, m_ecnt8 = 0, m_pcnt2 = 0, m_ecnt2 = 0;
    bit m_pd = 1'b0, m_err = 1'b0;

    typedef struct {
        logic [2:0] din;
        logic       valid;
        logic       clr;
        logic       lk;
        logic       er;
        logic       pd;
        logic [2:0] ex;
    } vec_t;
    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    function automatic int sat_inc(input int v, input int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic model_step(input logic [2:0] d, input logic v, input logic c, input logic r);
        bit was;
        m_pd  = 1'b0;
        m_err = 1'b0;
        if (r) begin
            m_run = 0;
            m_pcnt8 = 0; m_ecnt8 = 0; m_pcnt2 = 0; m_ecnt2 = 0;
        end else begin
            if (v) begin
                was = (m_run >= 7 * LOCK);
                if (m_run > 0 && d == pat[m_run % 7]) begin
                    m_run++;
                    m_pd = was && (m_run % 7 == 0);
                end else begin
                    m_err = was;
                    m_run = (d == 3'd1) ? 1 : 0;
                end
                if (m_run >= 7 * LOCK + 7) m_run -= 7;
            end
            if (c) begin
                m_pcnt8 = 0; m_ecnt8 = 0; m_pcnt2 = 0; m_ecnt2 = 0;
            end else begin
                if (m_pd) begin m_pcnt8 = sat_inc(m_pcnt8, 255); m_pcnt2 = sat_inc(m_pcnt2, 3); end
                if (m_err) begin m_ecnt8 = sat_inc(m_ecnt8, 255); m_ecnt2 = sat_inc(m_ecnt2, 3); end
            end
        end
    endtask

    task automatic cycle(input logic [2:0] d, input logic v, input logic c, input logic r);
        @(negedge clk);
        din = d; din_valid = v; cnt_clr = c; rst = r;
        @(posedge clk);
        model_step(d, v, c, r);
        #1;
    endtask

    task automatic check_model();
        logic lk;
        lk = (m_run >= 7 * LOCK);
        check("rnd_locked", locked, lk);
        check("rnd_expected", expected, pat[m_run % 7]);
        check("rnd_period_done", period_done, m_pd);
        check("rnd_err", err, m_err);
        check("rnd_period_cnt", period_cnt, m_pcnt8);
        check("rnd_err_cnt", err_cnt, m_ecnt8);
        check("rnd_s_locked", s_locked, lk);
        check("rnd_s_period_done", s_period_done, m_pd);
        check("rnd_s_err", s_err, m_err);
        check("rnd_s_period_cnt", s_period_cnt, m_pcnt2);
        check("rnd_s_err_cnt", s_err_cnt, m_ecnt2);
    endtask

    task automatic lock_up();
        cycle(3'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 7 * LOCK; k++) cycle(pat[k % 7], 1'b1, 1'b0, 1'b0);
        check("lock_up_locked", locked, 1);
    endtask

    logic [2:0] s2 [22] = '{3'd1, 3'd6, 3'd6, 3'd5, 3'd7, 3'd3, 3'd2, 3'd4,
                            3'd1, 3'd6, 3'd5, 3'd7, 3'd3, 3'd2, 3'd4,
                            3'd1, 3'd6, 3'd5, 3'd7, 3'd3, 3'd2, 3'd4};

    initial begin
        int pd_seen, err_seen;
        logic [2:0] d;
        logic r, v, c;

        rst = 1'b1; din = 3'd0; din_valid = 1'b0; cnt_clr = 1'b0;

        for (int k = 0; k < 14; k++)
            tbl.push_back('{pat[k % 7], 1'b1, 1'b0, 1'(k == 13), 1'b0, 1'b0, pat[(k + 1) % 7]});
        tbl.push_back('{3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1});
        tbl.push_back('{3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6});
        tbl.push_back('{3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5});
        tbl.push_back('{3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1});
        tbl.push_back('{3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6});

        // Reset state
        cycle(3'd0, 1'b0, 1'b0, 1'b1);
        check("rst_locked", locked, 0);
        check("rst_expected", expected, 1);
        check("rst_period_done", period_done, 0);
        check("rst_err", err, 0);
        check("rst_period_cnt", period_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);

        // Lock, hold across a gap, then break with 1,6,0
        foreach (tbl[i]) begin
            cycle(tbl[i].din, tbl[i].valid, tbl[i].clr, 1'b0);
            check($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
            check($sformatf("tbl%0d_err", i), err, tbl[i].er);
            check($sformatf("tbl%0d_period_done", i), period_done, tbl[i].pd);
            check($sformatf("tbl%0d_expected", i), expected, tbl[i].ex);
        end
        check("tbl_err_cnt", err_cnt, 1);
        check("tbl_period_cnt", period_cnt, 0);

        // Repeated value before first lock never raises err
        cycle(3'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 22; i++) begin
            cycle(s2[i], 1'b1, 1'b0, 1'b0);
            check($sformatf("startup%0d_err", i), err, 0);
            check($sformatf("startup%0d_locked", i), locked, (i == 21) ? 1 : 0);
        end
        check("startup_err_cnt", err_cnt, 0);

        // Valid gaps of 1..5 cycles inside periods
        lock_up();
        pd_seen = 0; err_seen = 0;
        for (int i = 0; i < 14; i++) begin
            for (int g = 0; g <= i % 5; g++) begin
                cycle(3'd0, 1'b0, 1'b0, 1'b0);
                check("gap_period_done", period_done, 0);
                check("gap_err", err, 0);
            end
            cycle(pat[i % 7], 1'b1, 1'b0, 1'b0);
            pd_seen += int'(period_done);
            err_seen += int'(err);
        end
        check("gap_pd_pulses", pd_seen, 2);
        check("gap_err_pulses", err_seen, 0);
        check("gap_period_cnt", period_cnt, 2);
        check("gap_locked", locked, 1);

        // 2-bit counter saturation, then clear coinciding with a period completion
        lock_up();
        for (int k = 0; k < 35; k++) cycle(pat[k % 7], 1'b1, 1'b0, 1'b0);
        check("sat_s_period_cnt", s_period_cnt, 3);
        check("sat_period_cnt", period_cnt, 5);
        for (int k = 0; k < 6; k++) cycle(pat[k], 1'b1, 1'b0, 1'b0);
        cycle(pat[6], 1'b1, 1'b1, 1'b0);
        check("clr_period_done", period_done, 1);
        check("clr_s_period_cnt", s_period_cnt, 0);
        check("clr_period_cnt", period_cnt, 0);

        // Reset mid-period while locked, then relock needs full LOCK periods
        lock_up();
        for (int k = 0; k < 10; k++) cycle(pat[k % 7], 1'b1, 1'b0, 1'b0);
        check("pre_rst_period_cnt", period_cnt, 1);
        cycle(pat[3], 1'b1, 1'b0, 1'b1);
        check("midrst_locked", locked, 0);
        check("midrst_period_cnt", period_cnt, 0);
        check("midrst_err_cnt", err_cnt, 0);
        check("midrst_expected", expected, 1);
        for (int k = 0; k < 14; k++) begin
            cycle(pat[k % 7], 1'b1, 1'b0, 1'b0);
            check($sformatf("relock%0d_locked", k), locked, (k == 13) ? 1 : 0);
        end

        // Random stimulus against the reference model
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 79) == 0);
            d = ($urandom_range(0, 99) < 95) ? pat[m_run % 7] : 3'($urandom_range(0, 7));
            cycle(d, v, c, r);
            check_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
